// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver (8N1, LSB first) plus a small ASCII command parser.
// A command character followed by CR produces a one-cycle cmd_req pulse that
// triggers the temperature/humidity report.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst_n         synchronous active-low reset
//   uart_rxd      asynchronous serial input, idle high
//   rx_data       last good byte, held until the next good byte
//   rx_valid      one-cycle strobe, rx_data updated in the same cycle
//   rx_frame_err  one-cycle strobe, stop bit sampled low
//   frame_err_cnt framing-error count, saturates at 255
//   cmd_req       one-cycle pulse one cycle after the rx_valid carrying CR
module uart_cmd_rx #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BIT_RATE     = 256000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter logic [7:0]  CMD_CHAR     = 8'h52
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    rx_frame_err,
  output logic [7:0]              frame_err_cnt,
  output logic                    cmd_req
);

  localparam int unsigned CPB = CLK_HZ / BIT_RATE;
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned IW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CW-1:0]           CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0]           CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [IW-1:0]           IDX_LAST = IW'(PAYLOAD_BITS - 1);
  localparam logic [PAYLOAD_BITS-1:0] BYTE_CMD = PAYLOAD_BITS'(CMD_CHAR);
  localparam logic [PAYLOAD_BITS-1:0] BYTE_CR  = PAYLOAD_BITS'(8'h0D);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  typedef enum logic {P_IDLE, P_CMD} p_state_t;

  logic                    r_rxd_meta;
  logic                    r_rxd_s;
  rx_state_t               r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [PAYLOAD_BITS-1:0] r_rx_data;
  logic                    r_rx_valid;
  logic                    r_rx_frame_err;
  logic [7:0]              r_err_cnt;
  p_state_t                r_pstate;
  logic                    r_cmd_req;

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_frame_err  = r_rx_frame_err;
  assign frame_err_cnt = r_err_cnt;
  assign cmd_req       = r_cmd_req;

  // Synchroniser resets to the idle-high line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
    end else begin
      r_rxd_meta <= uart_rxd;
      r_rxd_s    <= r_rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_err_cnt      <= '0;
    end else begin
      r_rx_valid     <= 1'b0;
      r_rx_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!r_rxd_s) r_state <= START;
        end
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_state <= r_rxd_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rxd_s;
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            // Leaving at mid-stop lets a following start bit be caught with no idle gap.
            if (r_rxd_s) begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_shift;
              r_state    <= IDLE;
            end else begin
              r_rx_frame_err <= 1'b1;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              r_state <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          r_cnt <= '0;
          if (r_rxd_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Command parser: consumes the registered byte strobes, so cmd_req lands one
  // cycle after the rx_valid that carries CR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pstate  <= P_IDLE;
      r_cmd_req <= 1'b0;
    end else begin
      r_cmd_req <= 1'b0;
      if (r_rx_frame_err) begin
        r_pstate <= P_IDLE;
      end else if (r_rx_valid) begin
        case (r_pstate)
          P_IDLE: r_pstate <= (r_rx_data == BYTE_CMD) ? P_CMD : P_IDLE;
          P_CMD: begin
            if (r_rx_data == BYTE_CR) begin
              r_cmd_req <= 1'b1;
              r_pstate  <= P_IDLE;
            end else if (r_rx_data == BYTE_CMD) begin
              r_pstate <= P_CMD;
            end else begin
              r_pstate <= P_IDLE;
            end
          end
          default: r_pstate <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] frame_err_cnt;
  logic       cmd_req;

  int unsigned checks;
  int unsigned errors;
  int unsigned n_valid;
  int unsigned n_err;
  int unsigned n_cmd;
  logic        prev_valid;
  logic        prev_strobe;

  uart_cmd_rx #(
    .CLK_HZ      (100_000_000),
    .BIT_RATE    (256000),
    .PAYLOAD_BITS(8),
    .CMD_CHAR    (8'h52)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .frame_err_cnt(frame_err_cnt),
    .cmd_req      (cmd_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: counts pulses and checks timing relations whenever one occurs.
  initial begin
    n_valid     = 0;
    n_err       = 0;
    n_cmd       = 0;
    prev_valid  = 1'b0;
    prev_strobe = 1'b0;
  end

  always @(negedge clk) begin
    if (cmd_req === 1'b1) begin
      checks++;
      n_cmd++;
      if (prev_valid !== 1'b1) begin
        errors++;
        $display("FAIL cmd_latency actual prev_rx_valid=%b required=1", prev_valid);
      end
    end
    if (rx_valid === 1'b1 || rx_frame_err === 1'b1) begin
      checks++;
      if ((rx_valid === 1'b1 && rx_frame_err === 1'b1) || prev_strobe === 1'b1) begin
        errors++;
        $display("FAIL strobe_excl actual valid=%b err=%b prev=%b required exclusive, not back-to-back",
                 rx_valid, rx_frame_err, prev_strobe);
      end
    end
    if (rx_valid === 1'b1) n_valid++;
    if (rx_frame_err === 1'b1) n_err++;
    prev_valid  = (rx_valid === 1'b1);
    prev_strobe = (rx_valid === 1'b1) || (rx_frame_err === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    chk({tag, "_rx_frame_err"}, 32'(rx_frame_err), 32'h0);
    chk({tag, "_frame_err_cnt"}, 32'(frame_err_cnt), 32'h0);
    chk({tag, "_cmd_req"}, 32'(cmd_req), 32'h0);
  endtask

  // Drives one frame starting at a negedge. A low stop bit is followed by
  // low_hold extra low cycles before the line returns high. rst_bit >= 0
  // pulses rst_n for one clock in the middle of that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned bc,
                            input int unsigned low_hold, input int rst_bit);
    uart_rxd = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      if (i == rst_bit) begin
        repeat (bc / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midframe_rst");
        rst_n = 1'b1;
        repeat (bc - bc / 2 - 1) @(negedge clk);
      end else begin
        repeat (bc) @(negedge clk);
      end
    end
    uart_rxd = stop;
    repeat (bc) @(negedge clk);
    if (!stop) begin
      repeat (low_hold) @(negedge clk);
      uart_rxd = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned bc;
    int unsigned hold;
    int unsigned exp_dv;
    int unsigned exp_de;
    int unsigned exp_dc;
    logic [7:0]  exp_data;
    logic [7:0]  exp_ecnt;
  } vec_t;

  vec_t vt[13];

  int unsigned v0, e0, c0;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    uart_rxd = 1'b1;

    //        data   stop  bc   hold  dv de dc  exp_data ecnt
    vt[0]  = '{8'h55, 1'b1, 390, 0,    1, 0, 0, 8'h55,  8'd0};
    vt[1]  = '{8'h52, 1'b1, 390, 0,    1, 0, 0, 8'h52,  8'd0};
    vt[2]  = '{8'h58, 1'b1, 390, 0,    1, 0, 0, 8'h58,  8'd0};
    vt[3]  = '{8'h0D, 1'b1, 390, 0,    1, 0, 0, 8'h0D,  8'd0};
    vt[4]  = '{8'h52, 1'b1, 390, 0,    1, 0, 0, 8'h52,  8'd0};
    vt[5]  = '{8'h52, 1'b1, 390, 0,    1, 0, 0, 8'h52,  8'd0};
    vt[6]  = '{8'h0D, 1'b1, 390, 0,    1, 0, 1, 8'h0D,  8'd0};
    vt[7]  = '{8'h52, 1'b1, 390, 0,    1, 0, 0, 8'h52,  8'd0};
    vt[8]  = '{8'hA3, 1'b0, 390, 2000, 0, 1, 0, 8'h52,  8'd1};
    vt[9]  = '{8'h0D, 1'b1, 390, 0,    1, 0, 0, 8'h0D,  8'd1};
    vt[10] = '{8'h31, 1'b1, 390, 0,    1, 0, 0, 8'h31,  8'd1};
    vt[11] = '{8'h55, 1'b1, 398, 0,    1, 0, 0, 8'h55,  8'd1};
    vt[12] = '{8'hAA, 1'b1, 382, 0,    1, 0, 0, 8'hAA,  8'd1};

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vt[k]) begin
      v0 = n_valid; e0 = n_err; c0 = n_cmd;
      send_frame(vt[k].data, vt[k].stop, vt[k].bc, vt[k].hold, -1);
      repeat (10) @(negedge clk);
      chk($sformatf("vec%0d_valid_cnt", k), n_valid - v0, vt[k].exp_dv);
      chk($sformatf("vec%0d_err_cnt", k), n_err - e0, vt[k].exp_de);
      chk($sformatf("vec%0d_cmd_cnt", k), n_cmd - c0, vt[k].exp_dc);
      chk($sformatf("vec%0d_rx_data", k), 32'(rx_data), 32'(vt[k].exp_data));
      chk($sformatf("vec%0d_frame_err_cnt", k), 32'(frame_err_cnt), 32'(vt[k].exp_ecnt));
    end

    // 'R' then CR with no idle gap between frames.
    v0 = n_valid; c0 = n_cmd;
    send_frame(8'h52, 1'b1, 390, 0, -1);
    send_frame(8'h0D, 1'b1, 390, 0, -1);
    repeat (20) @(negedge clk);
    chk("b2b_valid_cnt", n_valid - v0, 2);
    chk("b2b_cmd_cnt", n_cmd - c0, 1);
    chk("b2b_rx_data", 32'(rx_data), 32'h0D);

    // 100-cycle low glitch is a false start; then 0xA5 must still be received.
    v0 = n_valid; e0 = n_err;
    uart_rxd = 1'b0;
    repeat (100) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_valid_cnt", n_valid - v0, 0);
    chk("glitch_err_cnt", n_err - e0, 0);
    send_frame(8'hA5, 1'b1, 390, 0, -1);
    repeat (10) @(negedge clk);
    chk("after_glitch_valid_cnt", n_valid - v0, 1);
    chk("after_glitch_rx_data", 32'(rx_data), 32'hA5);

    // Reset pulse during bit 4; upper bits are all 1 so the tail cannot look like a start.
    v0 = n_valid; e0 = n_err;
    send_frame(8'hF5, 1'b1, 390, 0, 4);
    repeat (10) @(negedge clk);
    chk("rst_frame_valid_cnt", n_valid - v0, 0);
    chk("rst_frame_err_cnt", n_err - e0, 0);
    send_frame(8'h7E, 1'b1, 390, 0, -1);
    repeat (10) @(negedge clk);
    chk("after_rst_valid_cnt", n_valid - v0, 1);
    chk("after_rst_rx_data", 32'(rx_data), 32'h7E);
    chk("after_rst_frame_err_cnt", 32'(frame_err_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
